// File: rtl/spike_event_fifo.sv
// Spike event buffer: tags each neuron spike with a timestamp and inter-spike interval,
// queues events in a first-word-fall-through FIFO and reports drops on overflow.
module spike_event_fifo #(
   parameter int TS_WIDTH = 8,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  logic                spike_i,
   input  logic                clr_ovf_i,
   output logic                evt_valid_o,
   input  logic                evt_ready_i,
   output logic [TS_WIDTH-1:0] evt_ts_o,
   output logic [TS_WIDTH-1:0] evt_isi_o,
   output logic [CNT_W-1:0]    count_o,
   output logic                overflow_o,
   output logic [7:0]          drop_cnt_o
);

   localparam int                  PTR_W   = $clog2(DEPTH);
   localparam logic [TS_WIDTH-1:0] ISI_MAX = '1;

   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [TS_WIDTH-1:0] isi_q, isi_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                overflow_q, overflow_d;
   logic [7:0]          drop_cnt_q, drop_cnt_d;

   logic [TS_WIDTH-1:0] ts_mem_q  [DEPTH];
   logic [TS_WIDTH-1:0] isi_mem_q [DEPTH];

   logic valid, full, pop, push_ok, drop;

   assign valid   = (count_q != '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign pop     = valid & evt_ready_i;
   // A full FIFO still accepts a spike when the head leaves on the same edge.
   assign push_ok = spike_i & (~full | pop);
   assign drop    = spike_i & full & ~pop;

   // NOTE: every always_comb target gets a default first so no path can infer a latch.
   always_comb begin
      ts_d       = ts_q;
      isi_d      = isi_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;

      if (en_i) ts_d = ts_q + TS_WIDTH'(1);

      // ISI restarts on every spike, including dropped ones and while counting is paused.
      if (spike_i)                       isi_d = TS_WIDTH'(1);
      else if (en_i && isi_q != ISI_MAX) isi_d = isi_q + TS_WIDTH'(1);

      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (drop) begin
         overflow_d = 1'b1;
         if (clr_ovf_i)                drop_cnt_d = 8'd1;
         else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end else if (clr_ovf_i) begin
         overflow_d = 1'b0;
         drop_cnt_d = 8'd0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ts_q       <= '0;
         isi_q      <= ISI_MAX;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         ts_q       <= ts_d;
         isi_q      <= isi_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // NOTE: storage is not reset; outputs are masked while empty, so stale contents never show.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         ts_mem_q[wr_ptr_q]  <= ts_q;
         isi_mem_q[wr_ptr_q] <= isi_q;
      end
   end

   assign evt_valid_o = valid;
   assign evt_ts_o    = valid ? ts_mem_q[rd_ptr_q]  : '0;
   assign evt_isi_o   = valid ? isi_mem_q[rd_ptr_q] : '0;
   assign count_o     = count_q;
   assign overflow_o  = overflow_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: doc/spike_event_fifo.md
# spike_event_fifo

Downstream stage of the leaky integrate-and-fire neuron. Consumes its registered one-bit spike output, tags each spike with a free-running timestamp and an inter-spike interval (ISI), and buffers the events in a small first-word-fall-through FIFO. Events leave through a valid/ready handshake toward the readout/serializer logic. Overflow is reported by a sticky flag and a drop counter.

## Interface

- TS_WIDTH, 8: width of timestamp and ISI fields.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1: width of occupancy output (derived).

- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  reset; one clock, reset asynchronous and active-low.
- en_i  in  1  counter enable; gates timestamp and ISI counters only.
- spike_i  in  1  spike from neuron; one event per high cycle.
- clr_ovf_i  in  1  synchronous clear of overflow_o and drop_cnt_o.
- evt_valid_o  out  1  head entry available.
- evt_ready_i  in  1  consumer accepts head entry.
- evt_ts_o  out  TS_WIDTH  head entry timestamp.
- evt_isi_o  out  TS_WIDTH  head entry ISI.
- count_o  out  CNT_W  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: at least one spike dropped.
- drop_cnt_o  out  8  dropped spikes, saturates at 255.

## Operation

- Timestamp counter ts: reset 0; +1 per cycle while en_i=1, wraps modulo 2^TS_WIDTH; holds when en_i=0.
- ISI counter isi: reset all-ones (meaning "no previous spike"). Spike cycle: captured ISI = current isi, then isi <= 1. No-spike cycle with en_i=1: isi <= min(isi+1, all-ones). en_i=0: holds (also in spike cycle, captured value still taken, isi still loads 1).
- Push: spike_i=1 at an edge writes {ts, isi} as sampled at that edge into the FIFO.
- Pop: evt_valid_o & evt_ready_i at an edge removes the head entry.
- FIFO: circular buffer, read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH; occupancy counter 0..DEPTH. count_o = occupancy.
- evt_valid_o = (count_o != 0). evt_ts_o/evt_isi_o driven from head entry combinationally from storage; 0 when empty.
- Full (count_o=DEPTH) with push and pop same edge: pop and push both performed, count stays DEPTH, no drop.
- Full with push and no pop: spike dropped; overflow_o <= 1; drop_cnt_o <= min(drop_cnt_o+1, 255). ISI counter still reloads to 1 (ISI measures spike-to-spike regardless of drops).
- Empty with push and ready=1: no bypass; entry written, popped earliest next edge.
- clr_ovf_i=1: overflow_o and drop_cnt_o <= 0; a drop in the same cycle wins (overflow_o=1, drop_cnt_o=1).
- Consumer must hold evt_ready_i independent of evt_valid_o; data stable while valid & !ready.

## Timing

- Reset (rst_ni=0, asynchronous): all outputs immediately 0 (evt_valid_o, evt_ts_o, evt_isi_o, count_o, overflow_o, drop_cnt_o); ts=0, isi=all-ones, pointers 0. Reset mid-transfer discards all entries; first event after release has ISI all-ones.
- Spike high in cycle N (sampled at edge E_N): evt_valid_o high after E_N if FIFO was empty; latency spike-to-valid = 1 cycle.
- Back-to-back spikes on consecutive edges each produce an entry; second carries ISI=1 and ts one greater (en_i=1).
- Occupancy and overflow_o update at the same edge as the causing push/pop/drop.
- Throughput: one push and one pop per cycle sustained.

## Test plan

- Reset then en_i=1, single spike at ts=5 -> one event ts=5, isi=255 (TS_WIDTH=8), valid one cycle after spike, count_o=1; ready=1 pops it, count_o=0.
- Spikes at ts=10, 11, 20 with ready=1 -> events (10,255), (11,1), (20,9) in order, no overflow.
- ready=0, six spikes with DEPTH=4 -> count_o=4, overflow_o=1, drop_cnt_o=2; drain yields first four spikes in order; clr_ovf_i pulse -> overflow_o=0, drop_cnt_o=0.
- FIFO full, spike and ready=1 same edge -> count_o stays 4, no drop, new entry appears last in order.
- en_i=0 for 300 cycles between spikes -> second ISI equals first-spike-to-en-drop count only; with en_i=1 throughout and gap 300 -> ISI=255 saturated, ts wrapped modulo 256.
- Assert rst_ni low mid-cycle with 3 entries queued -> evt_valid_o, count_o drop to 0 before next edge; next spike after release reports isi=255, ts counted from 0.
